// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: Philips I2S master transmitter. Serialises stereo PCM pairs
// MSB-first, with SCK and WS derived from clk by an integer divider.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS      = 32,
  parameter int SCK_DIV        = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUMBER_OF_BITS-1:0] sample_left,
  input  logic [NUMBER_OF_BITS-1:0] sample_right,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO    = DIV_W'(0);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO    = BIT_W'(0);
  localparam logic [BIT_W-1:0] LEFT_FIRST  = BIT_W'(1);
  localparam logic [BIT_W-1:0] LEFT_LAST   = BIT_W'(NUMBER_OF_BITS);
  localparam logic [BIT_W-1:0] RIGHT_SLOT  = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_BITS + 1);
  localparam logic [BIT_W-1:0] RIGHT_LAST  = BIT_W'(SLOT_BITS + NUMBER_OF_BITS);
  localparam logic [NUMBER_OF_BITS-1:0] PCM_ZERO = {NUMBER_OF_BITS{1'b0}};

  logic [DIV_W-1:0]          div_cnt_r;
  logic                      sck_r;
  logic [BIT_W-1:0]          bit_cnt_r;
  logic                      ws_r;
  logic                      sd_r;
  logic [NUMBER_OF_BITS-1:0] left_shift_r;
  logic [NUMBER_OF_BITS-1:0] right_shift_r;
  logic [NUMBER_OF_BITS-1:0] hold_left_r;
  logic [NUMBER_OF_BITS-1:0] hold_right_r;
  logic                      hold_full_r;
  logic                      ready_r;
  logic                      frame_start_r;
  logic                      underrun_r;

  logic                      div_wrap_s;
  logic                      fall_s;
  logic [BIT_W-1:0]          bit_nxt_s;
  logic                      load_s;
  logic                      left_bit_s;
  logic                      right_bit_s;
  logic                      transfer_s;

  // Divider wrap, SCK fall detection, next bit position and handshake decode
  always_comb begin
    div_wrap_s = (div_cnt_r == DIV_LAST);
    fall_s     = div_wrap_s && sck_r;
    if (bit_cnt_r == BIT_LAST) begin
      bit_nxt_s = BIT_ZERO;
    end else begin
      bit_nxt_s = bit_cnt_r + BIT_ONE;
    end
    load_s      = fall_s && (bit_nxt_s == BIT_ZERO);
    left_bit_s  = (bit_nxt_s >= LEFT_FIRST) && (bit_nxt_s <= LEFT_LAST);
    right_bit_s = (bit_nxt_s >= RIGHT_FIRST) && (bit_nxt_s <= RIGHT_LAST);
    transfer_s  = sample_valid && ready_r;
  end

  // SCK divider: toggle sck every SCK_DIV clk cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= DIV_ZERO;
      sck_r     <= 1'b0;
    end else if (div_wrap_s) begin
      div_cnt_r <= DIV_ZERO;
      sck_r     <= ~sck_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Bit position, WS/SD launch on SCK falls, and frame load into the shifters
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r     <= BIT_LAST;
      ws_r          <= 1'b0;
      sd_r          <= 1'b0;
      left_shift_r  <= PCM_ZERO;
      right_shift_r <= PCM_ZERO;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        ws_r      <= (bit_nxt_s >= RIGHT_SLOT);
        if (load_s) begin
          // An empty holding register at load time sends a silent frame
          sd_r          <= 1'b0;
          frame_start_r <= 1'b1;
          underrun_r    <= ~hold_full_r;
          left_shift_r  <= hold_full_r ? hold_left_r : PCM_ZERO;
          right_shift_r <= hold_full_r ? hold_right_r : PCM_ZERO;
        end else if (left_bit_s) begin
          sd_r         <= left_shift_r[NUMBER_OF_BITS-1];
          left_shift_r <= left_shift_r << 1'b1;
        end else if (right_bit_s) begin
          sd_r          <= right_shift_r[NUMBER_OF_BITS-1];
          right_shift_r <= right_shift_r << 1'b1;
        end else begin
          sd_r <= 1'b0;
        end
      end else begin
        sd_r <= sd_r;
      end
    end
  end

  // Holding register and ready: a load sees the state before a same-edge transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_left_r  <= PCM_ZERO;
      hold_right_r <= PCM_ZERO;
      hold_full_r  <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      if (transfer_s) begin
        hold_left_r  <= sample_left;
        hold_right_r <= sample_right;
        hold_full_r  <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end else begin
        hold_full_r <= hold_full_r;
      end
      ready_r <= transfer_s ? 1'b0 : ~hold_full_r;
    end
  end

  assign sample_ready = ready_r;
  assign sck          = sck_r;
  assign ws           = ws_r;
  assign sd           = sd_r;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;

endmodule

// File: doc/pcm_to_i2s.md
Name: pcm_to_i2s

Overview:
I2S master transmitter; the transmit-side counterpart of the team's I2S-to-PCM receiver. It accepts stereo PCM sample pairs over a valid/ready handshake and serialises them MSB-first in Philips I2S format. It generates its own SCK and WS from clk. It drives beamformer output samples to an external DAC or codec, or back into the receiver for loopback test.

Parameters:
NUMBER_OF_BITS, 8, PCM sample width per channel; must be >= 1.
SLOT_BITS, 32, SCK periods per channel slot (half WS period); must be >= NUMBER_OF_BITS+1.
SCK_DIV, 1, clk cycles per SCK half-period; must be >= 1.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high.
sample_left  input  NUMBER_OF_BITS  left PCM sample, two's complement.
sample_right  input  NUMBER_OF_BITS  right PCM sample, two's complement.
sample_valid  input  1  the sample pair is valid.
sample_ready  output  1  the holding register can accept a pair.
sck  output  1  I2S bit clock.
ws  output  1  word select; 0 = left, 1 = right.
sd  output  1  serial data.
frame_start  output  1  one-clk pulse at each frame load.
underrun  output  1  one-clk pulse when a frame loads with the holding register empty.

Behaviour:
- All outputs are registered and change only on posedge clk.
- Reset values: sck=0, ws=0, sd=0, sample_ready=1, frame_start=0, underrun=0. Internal state on reset: div_cnt=0, bit_cnt=2*SLOT_BITS-1, holding empty, shift registers zero. Reset mid-frame aborts the frame; the held sample is discarded.
- SCK generation:
  - div_cnt counts 0..SCK_DIV-1; at SCK_DIV-1 it wraps and sck toggles.
  - A toggle from 1 to 0 is a "fall event".
  - After reset, the first rise occurs at clk edge SCK_DIV and the first fall at clk edge 2*SCK_DIV.
- Bit counter: bit_cnt advances only on fall events, modulo 2*SLOT_BITS.
- On each fall event, using the new bit_cnt value b:
  - ws <= (b >= SLOT_BITS).
  - sd <= left_shift[NUMBER_OF_BITS-1-(b-1)] for b in 1..NUMBER_OF_BITS (MSB first, one-SCK delay after the WS edge).
  - sd <= right_shift[NUMBER_OF_BITS-1-(b-SLOT_BITS-1)] for b in SLOT_BITS+1..SLOT_BITS+NUMBER_OF_BITS.
  - sd <= 0 at every other position, including b=0 and b=SLOT_BITS.
  - The receiver samples sd and ws on the SCK rising edge.
- Frame load, on the fall event where b wraps to 0:
  - If the holding register is full: left_shift/right_shift <= holding contents, holding <= empty, frame_start=1 for that clk.
  - If the holding register is empty: shift registers <= 0 (silence), frame_start=1 and underrun=1 for that clk.
  - The first fall after reset is a frame load.
- Handshake:
  - A transfer occurs on a clk edge where sample_valid && sample_ready. Holding captures both samples and sample_ready goes 0 on the next cycle.
  - sample_ready returns to 1 on the cycle after a frame load empties the holding register.
  - sample_valid while ready=0 is held off; the source must keep data stable.
- Simultaneous events: if a transfer and a frame load happen on the same clk edge while holding is empty, the load sees empty. It emits silence with underrun=1, and the new pair stays in holding for the next frame. There is no bypass path.
- Throughput: at most one sample pair per frame of 2*SLOT_BITS*2*SCK_DIV clk cycles.
- Sample values are sent verbatim with no sign extension; padding bits are always 0.

Test Plan:
1. N=8, SLOT_BITS=16, SCK_DIV=1; present L=0xA5, R=0x3C before the first fall. Required on frame 0:
   - ws=0 for 16 SCK, then 1 for 16 SCK.
   - sd at b=1..8 = 1,0,1,0,0,1,0,1; b=9..15 = 0.
   - sd at b=17..24 = 0,0,1,1,1,1,0,0.
   - frame_start=1 once and underrun=0.
2. Keep valid low after reset: the first frame's sd is all 0 and underrun pulses once per frame. Then present L=0x80, R=0x01: the next frame has sd=1 only at b=1 and b=24.
3. Back-pressure: hold valid high with a new pair every cycle. Required:
   - ready falls after the first accept and rises exactly one clk after each frame_start.
   - Each frame carries the pair accepted right after the previous load; no pair is skipped or duplicated.
4. Collision: assert the first valid on exactly the clk edge of a frame load. Required: that frame is silent with underrun=1, and the pair appears in the following frame.
5. Reset mid-frame: assert reset at b=5 of the left slot for one clk. Required:
   - sck=ws=sd=0 and ready=1 on the next cycle.
   - The discarded holding data is never transmitted.
   - The next frame starts 2*SCK_DIV clk after reset deasserts.
6. Boundary config N=8, SLOT_BITS=9, SCK_DIV=3:
   - The sck period is 6 clk.
   - L=0xFF gives sd=1 for b=1..8 and 0 at b=0/9.
   - There is no gap between slots, and the WS period is 108 clk.
